// File: rtl/xray_line_capture.sv
// Line capture for the X-ray sensor readout: frames each line from SENRST/SENCLK,
// samples the ADC a fixed delay after each pixel clock and streams captured pixels out of a FIFO.
module xray_line_capture #(
  parameter int DATA_W     = 12,
  parameter int NUM_PIX    = 128,
  parameter int SKIP_PIX   = 2,
  parameter int SAMPLE_DLY = 625,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              SENCLK,
  input  logic              SENRST,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_SOL,
  output logic              OUT_EOL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  input  logic              CLR_ERR,
  output logic              OVF,
  output logic              SHORT_LINE,
  output logic [15:0]       LINE_CNT,
  output logic              BUSY
);

  localparam int WORD_W  = DATA_W + 2;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int PIX_MAX = (NUM_PIX > SKIP_PIX) ? NUM_PIX : SKIP_PIX;
  localparam int CNT_W   = $clog2(PIX_MAX + 1);
  localparam int DLY_W   = 12;

  localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(SAMPLE_DLY);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_PIX > 0) ? SKIP_PIX - 1 : 0);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NUM_PIX - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   pix_cnt;
  logic [DLY_W-1:0]   dly_cnt;
  logic               senclk_q;
  logic               senrst_q;

  logic               senclk_rise;
  logic               senrst_rise;
  logic               line_start;
  logic               strobe;
  state_t             restart_state;

  logic [WORD_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [WORD_W-1:0]  push_word;
  logic [WORD_W-1:0]  rd_word;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               wr_en;
  logic               ovf_set;
  logic               short_set;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      senclk_q <= 1'b0;
      senrst_q <= 1'b0;
    end else begin
      senclk_q <= SENCLK;
      senrst_q <= SENRST;
    end
  end

  assign senclk_rise = SENCLK & ~senclk_q;
  assign senrst_rise = SENRST & ~senrst_q;

  // A SENRST rise only starts a line from IDLE when enabled, but always aborts a running line.
  assign line_start    = senrst_rise & ((state != S_IDLE) | ENABLE);
  assign strobe        = (dly_cnt == DLY_W'(1)) & ~line_start;
  assign restart_state = (SKIP_PIX == 0) ? S_CAP : S_SKIP;

  // Line start cancels any pending sample and swallows a coincident SENCLK rise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly_cnt <= '0;
    end else if (line_start) begin
      dly_cnt <= '0;
    end else if (senclk_rise) begin
      dly_cnt <= DLY_LOAD;
    end else if (dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DLY_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      pix_cnt  <= '0;
      LINE_CNT <= '0;
    end else if (line_start) begin
      state   <= restart_state;
      pix_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_SKIP: begin
          if (strobe) begin
            if (pix_cnt == SKIP_LAST) begin
              state   <= S_CAP;
              pix_cnt <= '0;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        S_CAP: begin
          // The line ends on the EOL strobe even if the FIFO had to drop that word.
          if (strobe) begin
            if (pix_cnt == PIX_LAST) begin
              state    <= S_IDLE;
              pix_cnt  <= '0;
              LINE_CNT <= LINE_CNT + 16'd1;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);

  assign push      = strobe & (state == S_CAP);
  assign push_word = {ADC_DATA, (pix_cnt == '0), (pix_cnt == PIX_LAST)};
  assign pop       = OUT_VALID & OUT_READY;
  assign fifo_full = (occ == FULL_OCC);
  assign wr_en     = push & (~fifo_full | pop);
  assign ovf_set   = push & fifo_full & ~pop;
  assign short_set = line_start & (state == S_CAP);

  // NOTE: the storage array carries no reset; only pointers and occupancy need
  // one, and reads are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign OUT_VALID = (occ != '0);
  assign rd_word   = mem[rd_ptr];
  assign OUT_DATA  = OUT_VALID ? rd_word[WORD_W-1:2] : '0;
  assign OUT_SOL   = OUT_VALID & rd_word[1];
  assign OUT_EOL   = OUT_VALID & rd_word[0];

  // Sticky error flags: a set event in the same cycle as CLR_ERR wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF        <= 1'b0;
      SHORT_LINE <= 1'b0;
    end else begin
      OVF        <= ovf_set   | (OVF & ~CLR_ERR);
      SHORT_LINE <= short_set | (SHORT_LINE & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_xray_line_capture.sv
// Bench for xray_line_capture: table-driven line capture, hand-written corner
// sequences and a randomized run against a line-level reference model.
module tb_xray_line_capture;

  localparam int DW    = 12;
  localparam int SKIP  = 2;
  localparam int NPA   = 4;
  localparam int NPB   = 6;
  localparam int DLY   = 3;
  localparam int DEPTH = 4;

  typedef logic [DW+1:0] word_t;

  typedef struct {
    logic [DW-1:0] adc;
    logic          exp_push;
    logic [DW-1:0] exp_data;
    logic          exp_sol;
    logic          exp_eol;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          senclk = 1'b0;
  logic          senrst = 1'b0;
  logic          out_ready = 1'b1;
  logic          clr_err = 1'b0;
  logic [DW-1:0] adc_data = '0;

  logic [DW-1:0] data_a, data_b;
  logic          sol_a, eol_a, valid_a, ovf_a, short_a, busy_a;
  logic          sol_b, eol_b, valid_b, ovf_b, short_b, busy_b;
  logic [15:0]   lcnt_a, lcnt_b;

  xray_line_capture #(.DATA_W(DW), .NUM_PIX(NPA), .SKIP_PIX(SKIP),
                      .SAMPLE_DLY(DLY), .FIFO_DEPTH(DEPTH)) dut_a (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .SENCLK(senclk), .SENRST(senrst),
    .ADC_DATA(adc_data), .OUT_DATA(data_a), .OUT_SOL(sol_a), .OUT_EOL(eol_a),
    .OUT_VALID(valid_a), .OUT_READY(out_ready), .CLR_ERR(clr_err), .OVF(ovf_a),
    .SHORT_LINE(short_a), .LINE_CNT(lcnt_a), .BUSY(busy_a));

  xray_line_capture #(.DATA_W(DW), .NUM_PIX(NPB), .SKIP_PIX(SKIP),
                      .SAMPLE_DLY(DLY), .FIFO_DEPTH(DEPTH)) dut_b (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .SENCLK(senclk), .SENRST(senrst),
    .ADC_DATA(adc_data), .OUT_DATA(data_b), .OUT_SOL(sol_b), .OUT_EOL(eol_b),
    .OUT_VALID(valid_b), .OUT_READY(out_ready), .CLR_ERR(clr_err), .OVF(ovf_b),
    .SHORT_LINE(short_b), .LINE_CNT(lcnt_b), .BUSY(busy_b));

  always #5 clk = ~clk;

  word_t q_a[$];
  word_t q_b[$];

  // Record every transferred word; pops happen on the following rising edge.
  always @(negedge clk) begin
    if (valid_a && out_ready) q_a.push_back({data_a, sol_a, eol_a});
    if (valid_b && out_ready) q_b.push_back({data_b, sol_b, eol_b});
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    senclk  = 1'b0;
    senrst  = 1'b0;
    clr_err = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic line_start();
    senrst = 1'b1;
    tick(3);
    senrst = 1'b0;
    tick(3);
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    adc_data = d;
    senclk   = 1'b1;
    tick(5);
    senclk = 1'b0;
    tick(5);
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) pulse(DW'(32'h100 + k));
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  vec_t vecs[6];

  word_t exp_q[$];
  bit    m_busy;
  int    m_idx;
  int    m_lines;
  bit    m_short;

  initial begin
    vecs[0] = '{12'h100, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[1] = '{12'h101, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[2] = '{12'h102, 1'b1, 12'h102, 1'b1, 1'b0};
    vecs[3] = '{12'h103, 1'b1, 12'h103, 1'b0, 1'b0};
    vecs[4] = '{12'h104, 1'b1, 12'h104, 1'b0, 1'b0};
    vecs[5] = '{12'h105, 1'b1, 12'h105, 1'b0, 1'b1};

    // Reset state, both during and after reset.
    rst_n = 1'b0;
    tick(2);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_sol_eol", {sol_a, eol_a}, 0);
    check("rst_flags", {ovf_a, short_a}, 0);
    check("rst_line_cnt", lcnt_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_valid", valid_a, 0);

    // Line capture with sample latency, one table entry per SENCLK rise.
    q_a.delete();
    line_start();
    check("busy_after_start", busy_a, 1);
    for (int i = 0; i < 6; i++) begin
      adc_data = vecs[i].adc;
      senclk   = 1'b1;
      tick(3);
      check($sformatf("vec%0d_valid_early", i), valid_a, 0);
      tick(1);
      check($sformatf("vec%0d_valid", i), valid_a, vecs[i].exp_push);
      if (vecs[i].exp_push) begin
        check($sformatf("vec%0d_data", i), data_a, vecs[i].exp_data);
        check($sformatf("vec%0d_sol", i), sol_a, vecs[i].exp_sol);
        check($sformatf("vec%0d_eol", i), eol_a, vecs[i].exp_eol);
      end
      tick(1);
      senclk = 1'b0;
      tick(5);
    end
    check("cap_line_cnt", lcnt_a, 1);
    check("cap_busy_end", busy_a, 0);
    check("cap_words", q_a.size(), 4);

    // Backpressure and overflow on the six-pixel instance.
    do_reset();
    q_b.delete();
    out_ready = 1'b0;
    line_start();
    pulses(8);
    check("bp_ovf", ovf_b, 1);
    check("bp_line_cnt", lcnt_b, 1);
    check("bp_busy", busy_b, 0);
    check("bp_hold_data", {valid_b, data_b, sol_b}, {1'b1, 12'h102, 1'b1});
    out_ready = 1'b1;
    tick(10);
    check("bp_drain_cnt", q_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_b.size())
        check($sformatf("bp_word%0d", i), q_b[i], {DW'(32'h102 + i), (i == 0), 1'b0});
    end
    check("bp_empty", valid_b, 0);
    clear_errors();
    check("bp_ovf_clr", ovf_b, 0);

    // Abort after two captured pixels, then a full restarted line.
    do_reset();
    q_a.delete();
    line_start();
    pulses(4);
    check("ab_short_pre", short_a, 0);
    line_start();
    check("ab_short", short_a, 1);
    check("ab_line_cnt", lcnt_a, 0);
    check("ab_busy", busy_a, 1);
    pulses(6);
    tick(2);
    check("ab_words", q_a.size(), 6);
    if (q_a.size() == 6) begin
      check("ab_old_word1", q_a[1], {12'h103, 1'b0, 1'b0});
      check("ab_new_first", q_a[2], {12'h102, 1'b1, 1'b0});
      check("ab_new_last", q_a[5], {12'h105, 1'b0, 1'b1});
    end
    check("ab_line_cnt_end", lcnt_a, 1);
    clear_errors();
    check("ab_short_clr", short_a, 0);

    // SENRST and SENCLK rising together: that SENCLK edge is not counted.
    do_reset();
    q_a.delete();
    adc_data = 12'hEEE;
    senrst   = 1'b1;
    senclk   = 1'b1;
    tick(5);
    senrst = 1'b0;
    senclk = 1'b0;
    tick(5);
    pulses(6);
    tick(2);
    check("co_words", q_a.size(), 4);
    if (q_a.size() > 0) check("co_first", q_a[0], {12'h102, 1'b1, 1'b0});
    check("co_line_cnt", lcnt_a, 1);

    // Asynchronous reset in the middle of a captured line.
    do_reset();
    q_a.delete();
    line_start();
    pulses(6);
    out_ready = 1'b0;
    line_start();
    pulses(5);
    check("mr_pre_valid", valid_a, 1);
    check("mr_pre_line_cnt", lcnt_a, 1);
    rst_n = 1'b0;
    #2;
    check("mr_valid", valid_a, 0);
    check("mr_flags", {ovf_a, short_a, busy_a}, 0);
    check("mr_line_cnt", lcnt_a, 0);
    tick(1);
    rst_n     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    tick(1);
    q_a.delete();
    line_start();
    check("dis_busy", busy_a, 0);
    pulses(6);
    check("dis_busy_end", busy_a, 0);
    check("dis_words", q_a.size(), 0);

    // Randomized lines against a line-level model.
    enable = 1'b1;
    do_reset();
    q_a.delete();
    exp_q.delete();
    m_busy  = 0;
    m_idx   = 0;
    m_lines = 0;
    m_short = 0;
    for (int ev = 0; ev < 80; ev++) begin
      if ($urandom_range(0, 4) == 0) begin
        enable = ($urandom_range(0, 3) != 0);
        if (m_busy || enable) begin
          if (m_busy && m_idx >= SKIP) m_short = 1;
          m_busy = 1;
          m_idx  = 0;
        end
        line_start();
      end else begin
        logic [DW-1:0] d;
        d = DW'($urandom());
        if (m_busy) begin
          if (m_idx >= SKIP)
            exp_q.push_back({d, (m_idx == SKIP), (m_idx == SKIP + NPA - 1)});
          m_idx++;
          if (m_idx == SKIP + NPA) begin
            m_busy = 0;
            m_lines++;
          end
        end
        pulse(d);
      end
    end
    tick(3);
    check("rnd_words", q_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < q_a.size()) check($sformatf("rnd_word%0d", i), q_a[i], exp_q[i]);
    end
    check("rnd_line_cnt", lcnt_a, m_lines & 32'hFFFF);
    check("rnd_short", short_a, m_short);
    check("rnd_busy", busy_a, m_busy);
    check("rnd_ovf", ovf_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xray_line_capture.md
Name: xray_line_capture

Overview:
- Readout stage directly downstream of the X-ray sensor timing generator. It consumes the SENCLK/SENRST pair that the generator drives to the sensor and samples the sensor's digitised video (external ADC) once per pixel clock.
- Frames each line and discards the leading dummy pixels.
- Buffers samples in a small FIFO and presents them as a valid/ready stream with start/end-of-line markers for the downstream host interface.

Parameters:
- DATA_W, 12, ADC sample width.
- NUM_PIX, 128, captured pixels per line.
- SKIP_PIX, 2, pixels discarded after each line start.
- SAMPLE_DLY, 625, CLK cycles from the SENCLK rising edge to the ADC sample point (1..4095).
- FIFO_DEPTH, 16, FIFO entries (power of two, >=2).

Ports:
- CLK  in  1  system clock (100 MHz), the same clock that generates SENCLK/SENRST
- RST_N  in  1  reset, asynchronous, active-low
- ENABLE  in  1  capture enable, honoured only in IDLE
- SENCLK  in  1  sensor pixel clock, synchronous to CLK (registered copy of the timing-stage output)
- SENRST  in  1  sensor line reset, synchronous to CLK
- ADC_DATA  in  DATA_W  digitised sensor video
- OUT_DATA  out  DATA_W  stream data
- OUT_SOL  out  1  first captured pixel of the line
- OUT_EOL  out  1  last captured pixel of the line
- OUT_VALID  out  1  stream word valid
- OUT_READY  in  1  downstream accepts word
- CLR_ERR  in  1  single-cycle pulse that clears the sticky flags
- OVF  out  1  sticky: a sample was dropped because the FIFO was full
- SHORT_LINE  out  1  sticky: a line was aborted by a new SENRST rise
- LINE_CNT  out  16  count of completed lines, wraps 0xFFFF->0
- BUSY  out  1  FSM not in IDLE

Behaviour:
- Reset (RST_N low, async): FSM=IDLE, FIFO empty, delay counter cleared, edge-detect registers=0. Outputs after reset: OUT_VALID=0, OUT_DATA=0, OUT_SOL=0, OUT_EOL=0, OVF=0, SHORT_LINE=0, LINE_CNT=0, BUSY=0.
- Edge detect: SENCLK and SENRST are each registered once; a rise is prev=0 and cur=1. Falling edges are ignored.
- Sample strobe: a SENCLK rise loads the delay counter with SAMPLE_DLY. The strobe fires when the counter reaches 1, i.e. SAMPLE_DLY cycles after the rise-detect cycle. A new SENCLK rise while the counter is running reloads it, so the earlier strobe is lost.
- States:
  - IDLE: on a SENRST rise with ENABLE=1, go to SKIP, clear the pixel counter and cancel any pending strobe.
  - SKIP: each strobe increments the pixel counter. When SKIP_PIX strobes have been counted, go to CAP with the counter at 0. If SKIP_PIX=0, go straight to CAP.
  - CAP: each strobe pushes {ADC_DATA, SOL=(cnt==0), EOL=(cnt==NUM_PIX-1)} and increments the counter. After the EOL push, go to IDLE and increment LINE_CNT.
- ENABLE low mid-line does not abort; the line completes.
- SENRST rise in SKIP or CAP:
  - Abort the current line and restart in SKIP with the counter at 0.
  - Cancel any pending strobe.
  - Set SHORT_LINE only if abort occurs in CAP.
  - LINE_CNT is not incremented. Already-queued words stay in the FIFO; no EOL is emitted for the aborted line.
- SENRST rise and SENCLK rise in the same cycle: the line start wins and that SENCLK edge is not counted.
- Strobe and SENRST rise in the same cycle: the strobe is discarded.
- FIFO:
  - Storage is DATA_W+2 bits wide, FIFO_DEPTH entries.
  - A push at the cycle-N strobe makes the word visible with OUT_VALID=1 in cycle N+1. There is no same-cycle bypass.
  - A word transfers on OUT_VALID & OUT_READY.
  - OUT_DATA, OUT_SOL and OUT_EOL hold stable while OUT_VALID=1 and OUT_READY=0.
  - Push when full with no pop in the same cycle: the sample is dropped and OVF is set. The pixel counter still advances, and an EOL drop still ends the line and increments LINE_CNT.
  - Push and pop in the same cycle when full: both are accepted.
  - Pop when empty: impossible, because OUT_VALID=0.
- CLR_ERR clears OVF and SHORT_LINE. If a set event occurs in the same cycle as CLR_ERR, set wins.
- Pointers wrap modulo FIFO_DEPTH; occupancy is tracked in a log2(FIFO_DEPTH)+1 bit counter.

Test Plan:
- Bench parameters: SAMPLE_DLY=3, SKIP_PIX=2, NUM_PIX=4, FIFO_DEPTH=4, OUT_READY=1, SENCLK period 10 cycles, ADC_DATA = pixel index+0x100.
- Line capture: SENRST rise, then 6 SENCLK rises -> stream 0x102(SOL), 0x103, 0x104, 0x105(EOL); LINE_CNT=1; BUSY low after EOL; each OUT_VALID lands 4 cycles after its SENCLK rise-detect.
- Backpressure/overflow: OUT_READY=0 for a full line with NUM_PIX=6 -> 4 words queued, OVF=1, LINE_CNT=1. After OUT_READY=1, exactly 0x102..0x105 drain in order, SOL on 0x102 only, no EOL. CLR_ERR -> OVF=0.
- Abort: second SENRST rise after 2 captured pixels -> SHORT_LINE=1, LINE_CNT unchanged. The new line restarts with SKIP, and its first word carries SOL.
- Coincident edges: SENRST and SENCLK rising in the same cycle -> that SENCLK edge is not counted, and the first captured pixel is the 3rd subsequent SENCLK rise.
- Reset mid-line: assert RST_N=0 during CAP with 3 words queued -> OUT_VALID=0, all flags 0, LINE_CNT=0 immediately (async). ENABLE=0 then blocks the next SENRST rise: BUSY stays 0 and no words are produced.
